uart_autobaud: RTL and testbench
================================

Name: uart_autobaud

Overview:
Auto-baud detector: measures the bit time of an incoming 0x55 ('U') sync character on the RX line. Converts that bit time into the 12-bit UBRR value (clocks per bit) that the baud generator consumes. Sits between the UART RX pin and the baud generator's UBRR input, so the link rate can be learned at run time instead of programmed.

Parameters:
UBRR_W, 12, width of UBRR result (clocks per bit)
MIN_UBRR, 4, smallest accepted result; anything smaller is flagged as error
CNT_W, UBRR_W+3, measurement counter width (8 bit periods)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: arm a new measurement
rx  input  1  asynchronous UART line, idle high
UBRR  output  UBRR_W  last successfully measured clocks-per-bit value
ubrr_valid  output  1  UBRR holds a good measurement
ubrr_changed  output  1  one-cycle pulse when UBRR is updated to a different value
busy  output  1  measurement in progress (any state except IDLE)
err  output  1  last measurement failed; sticky until next start

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- rx passes through a 2-flop synchronizer (rx_s). Edges are detected on rx_s against its previous value. The fixed 2-cycle delay applies to every edge, so it does not bias the result.
- Reset values: UBRR=0, ubrr_valid=0, ubrr_changed=0, busy=0, err=0, FSM=IDLE, counters=0.
- IDLE: wait for start. On start: clear err and ubrr_valid, then go to ARM. UBRR keeps its old value.
- ARM: wait for rx_s==1 (line idle), then go to WAIT_START.
- WAIT_START: on the first falling edge of rx_s, set cnt=0 and edges=1, then go to MEASURE.
- MEASURE: cnt increments every cycle.
  - Each falling edge increments edges.
  - 0x55 framing gives falling edges at start, b1, b3, b5 and b7, so the span from edge 1 to edge 5 is exactly 8 bit times.
  - On the cycle the 5th falling edge is detected, latch meas=cnt (exact clock count between the two edges), then go to WAIT_STOP.
- WAIT_STOP: wait for rx_s rising (end of b7, start of stop bit). A 2^CNT_W-cycle timeout applies here as well. Then go to CALC.
- CALC (1 cycle): res = (meas + 4) >> 3, computed at CNT_W+1 bits (round to nearest).
  - Error if res < MIN_UBRR or res > 2^UBRR_W-1.
  - On success: UBRR=res and ubrr_valid=1.
  - ubrr_changed pulses for exactly 1 cycle if res differs from the previous UBRR. The pulse is aligned with the UBRR update.
  - Return to IDLE.
- Timeout: if cnt would pass 2^CNT_W-1 in MEASURE, or WAIT_STOP times out, set err=1 and ubrr_valid=0, then go to IDLE. UBRR is unchanged.
- Error path: err=1, ubrr_valid=0, no ubrr_changed pulse, UBRR is unchanged.
- start while busy restarts from ARM and clears err and ubrr_valid. Any partial measurement is discarded.
- rst at any time, including mid-MEASURE, returns everything to reset values on the next edge.
- Latency: ubrr_valid rises 2 cycles after the synchronized stop-bit rising edge (WAIT_STOP to CALC to IDLE with registered outputs). ubrr_changed is coincident with that rise.

Optional Feature:
Macro UART_AUTOBAUD_CHECK_EN.
- Defined: each of the four falling-edge-to-falling-edge intervals (nominally 2 bit times) is captured. If any interval differs from meas/4 by more than meas/16 (±25% of one interval), CALC takes the error path: err=1, ubrr_valid=0, no update. This rejects non-0x55 characters and glitches.
- Not defined: only the total 8-bit span is used and no per-interval check is performed.

Test Plan:
- start, then 0x55 at 868 clocks/bit → meas=6944, UBRR=868, ubrr_valid=1, one ubrr_changed pulse, err=0.
- Repeat the same 868 clocks/bit frame → UBRR stays 868, ubrr_valid=1, no ubrr_changed pulse.
- 0x55 at 16 clocks/bit, then at 3 clocks/bit → first gives UBRR=16; second gives err=1, ubrr_valid=0, UBRR stays 16.
- 0x55 at 10416 clocks/bit (exceeds 12 bits) → err=1 via timeout (cnt overflows 32767), busy returns to 0, UBRR unchanged.
- Start bit then rx held low; separately, rst pulsed mid-MEASURE → err=1 after 32768 cycles for the held-low case; reset case clears all outputs to 0 and FSM returns to IDLE.
- With UART_AUTOBAUD_CHECK_EN: send 0x5D at 100 clocks/bit (one interval distorted) → err=1, no update. Without the macro: a result is produced and no error is flagged.

Source files
------------

// File: rtl/uart_autobaud.sv
// uart_autobaud: learns the UART bit time from a 0x55 sync character and
// converts it into the clocks-per-bit UBRR value for the baud generator.
// Optional build macro UART_AUTOBAUD_CHECK_EN adds a per-interval sanity
// check that rejects characters whose falling edges are not evenly spaced.
module uart_autobaud #(
    parameter int unsigned UBRR_W   = 12,
    parameter int unsigned MIN_UBRR = 4,
    parameter int unsigned CNT_W    = UBRR_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx,
    output logic [UBRR_W-1:0] UBRR,
    output logic              ubrr_valid,
    output logic              ubrr_changed,
    output logic              busy,
    output logic              err
);

    // One extra bit so a span of exactly 2^CNT_W clocks still fits.
    localparam int unsigned MEAS_W = CNT_W + 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ARM        = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_MEASURE    = 3'd3;
    localparam logic [2:0] S_WAIT_STOP  = 3'd4;
    localparam logic [2:0] S_CALC       = 3'd5;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [MEAS_W-1:0] UBRR_MAX  = MEAS_W'({UBRR_W{1'b1}});
    localparam logic [MEAS_W-1:0] UBRR_MIN  = MEAS_W'(MIN_UBRR);

    logic              rx_m, rx_s, rx_d;
    logic              fall, rise;
    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        edges, edges_nxt;
    logic [MEAS_W-1:0] meas, meas_nxt;
    logic [MEAS_W-1:0] pos;
    logic [MEAS_W-1:0] res;
    logic              res_bad;
    logic              chk_fail;
    logic [UBRR_W-1:0] ubrr_nxt;
    logic              valid_nxt, changed_nxt, busy_nxt, err_nxt;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;
    assign rise = ~rx_d & rx_s;

    // Clocks elapsed since the first falling edge, counting the current cycle.
    assign pos = MEAS_W'(cnt) + MEAS_W'(1);

    // Round-to-nearest divide of the 8-bit span by 8, range checked.
    assign res     = (meas + MEAS_W'(4)) >> 3;
    assign res_bad = (res < UBRR_MIN) || (res > UBRR_MAX);

`ifdef UART_AUTOBAUD_CHECK_EN
    logic [MEAS_W-1:0] iv [4];
    logic [MEAS_W-1:0] last_pos;
    logic [1:0]        iv_idx;

    assign iv_idx = 2'(edges - 3'd1);

    // Capture the four edge-to-edge intervals while measuring.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) iv[i] <= '0;
            last_pos <= '0;
        end else if (state == S_WAIT_START && fall) begin
            last_pos <= '0;
        end else if (state == S_MEASURE && fall && !start) begin
            iv[iv_idx] <= pos - last_pos;
            last_pos   <= pos;
        end
    end

    // Any interval off its nominal quarter-span by more than span/16 fails.
    always_comb begin : chk_calc
        logic [MEAS_W-1:0] quarter;
        logic [MEAS_W-1:0] tol;
        logic [MEAS_W-1:0] dev;
        chk_fail = 1'b0;
        quarter  = meas >> 2;
        tol      = meas >> 4;
        dev      = '0;
        for (int i = 0; i < 4; i++) begin
            dev = (iv[i] > quarter) ? (iv[i] - quarter) : (quarter - iv[i]);
            if (dev > tol) chk_fail = 1'b1;
        end
    end
`else
    assign chk_fail = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            edges        <= '0;
            meas         <= '0;
            UBRR         <= '0;
            ubrr_valid   <= 1'b0;
            ubrr_changed <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            edges        <= edges_nxt;
            meas         <= meas_nxt;
            UBRR         <= ubrr_nxt;
            ubrr_valid   <= valid_nxt;
            ubrr_changed <= changed_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        edges_nxt   = edges;
        meas_nxt    = meas;
        ubrr_nxt    = UBRR;
        valid_nxt   = ubrr_valid;
        changed_nxt = 1'b0;
        err_nxt     = err;

        case (state)
            S_IDLE: begin
            end
            S_ARM: begin
                if (rx_s) state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (fall) begin
                    cnt_nxt   = '0;
                    edges_nxt = 3'd1;
                    state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (fall && edges == 3'd4) begin
                    meas_nxt  = pos;
                    cnt_nxt   = '0;
                    edges_nxt = 3'd5;
                    state_nxt = S_WAIT_STOP;
                end else begin
                    if (fall) edges_nxt = edges + 3'd1;
                    if (cnt == CNT_MAX) begin
                        err_nxt   = 1'b1;
                        valid_nxt = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_STOP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (rise) begin
                    state_nxt = S_CALC;
                end else if (cnt == CNT_MAX) begin
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                state_nxt = S_IDLE;
                if (res_bad || chk_fail) begin
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b0;
                end else begin
                    ubrr_nxt    = UBRR_W'(res);
                    valid_nxt   = 1'b1;
                    changed_nxt = (UBRR_W'(res) != UBRR);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A start pulse always (re)arms, discarding any partial measurement.
        if (start) begin
            state_nxt   = S_ARM;
            cnt_nxt     = '0;
            edges_nxt   = '0;
            err_nxt     = 1'b0;
            valid_nxt   = 1'b0;
            changed_nxt = 1'b0;
            ubrr_nxt    = UBRR;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: scoreboard bench. Each stimulus frame is described as a
// list of (level, duration) line segments; a waveform-level model predicts
// the outcome and a monitor checks it when the DUT leaves busy.
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx;
    logic [11:0] UBRR;
    logic        ubrr_valid;
    logic        ubrr_changed;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          err;
        bit          valid;
        int unsigned ubrr;
        bit          changed;
    } exp_t;

    exp_t        exp_q[$];
    bit          seg_lvl[$];
    int unsigned seg_len[$];
    int unsigned model_ubrr  = 0;
    int          exp_changes = 0;
    int          obs_changes = 0;
    bit          mon_en      = 1'b0;
    bit          busy_q      = 1'b0;
    bit          chg_q       = 1'b0;

    uart_autobaud dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx           (rx),
        .UBRR         (UBRR),
        .ubrr_valid   (ubrr_valid),
        .ubrr_changed (ubrr_changed),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add_seg(input bit lvl, input int unsigned len);
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
    endtask

    // Start bit, 8 data bits LSB first, stop bit.
    task automatic build_char(input logic [7:0] ch, input int unsigned b);
        add_seg(1'b0, b);
        for (int i = 0; i < 8; i++) add_seg(ch[i], b);
        add_seg(1'b1, b);
    endtask

    // Predict the outcome from the line waveform: first-to-fifth falling
    // edge span, next rising edge, rounding and range rules.
    task automatic predict();
        int unsigned falls[$];
        int unsigned rises[$];
        int unsigned t = 0;
        bit          prev = 1'b1;
        bit          bad = 1'b0;
        bit          found = 1'b0;
        int unsigned span = 0;
        int unsigned res = 0;
        int unsigned r = 0;
        exp_t        e;
        for (int i = 0; i < seg_lvl.size(); i++) begin
            if (prev && !seg_lvl[i]) falls.push_back(t);
            if (!prev && seg_lvl[i]) rises.push_back(t);
            t += seg_len[i];
            prev = seg_lvl[i];
        end
        if (!prev) rises.push_back(t);
        if (falls.size() < 5) begin
            bad = 1'b1;
        end else begin
            span = falls[4] - falls[0];
            if (span > 32768) bad = 1'b1;
            for (int k = 0; k < rises.size(); k++) begin
                if (!found && rises[k] > falls[4]) begin
                    found = 1'b1;
                    r = rises[k];
                end
            end
            if (!found || (r - falls[4]) > 32768) bad = 1'b1;
            res = (span + 4) / 8;
            if (res < 4 || res > 4095) bad = 1'b1;
`ifdef UART_AUTOBAUD_CHECK_EN
            for (int k = 0; k < 4; k++) begin
                int iv;
                int diff;
                iv   = int'(falls[k+1] - falls[k]);
                diff = iv - int'(span / 4);
                if (diff < 0) diff = -diff;
                if (diff > int'(span / 16)) bad = 1'b1;
            end
`endif
        end
        if (bad) begin
            e.err = 1'b1; e.valid = 1'b0; e.ubrr = model_ubrr; e.changed = 1'b0;
        end else begin
            e.err = 1'b0; e.valid = 1'b1; e.ubrr = res; e.changed = (res != model_ubrr);
            model_ubrr = res;
        end
        if (e.changed) exp_changes++;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check1("start_busy", 32'(busy), 32'd1);
        check1("start_err_clr", 32'(err), 32'd0);
        check1("start_valid_clr", 32'(ubrr_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drive_segs();
        for (int i = 0; i < seg_lvl.size(); i++) begin
            rx = seg_lvl[i];
            repeat (seg_len[i]) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        seg_lvl.delete();
        seg_len.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) check1("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_frame();
        pulse_start();
        predict();
        drive_segs();
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Monitor: compare against the scoreboard whenever a measurement ends.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ubrr_changed) begin
                obs_changes++;
                check1("changed_alignment", 32'(chg_q || !(busy_q && !busy)), 32'd0);
            end
            if (busy_q && !busy) begin
                if (exp_q.size() == 0) begin
                    check1("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check1("err", 32'(err), 32'(e.err));
                    check1("ubrr_valid", 32'(ubrr_valid), 32'(e.valid));
                    check1("UBRR", 32'(UBRR), e.ubrr);
                    check1("ubrr_changed", 32'(ubrr_changed), 32'(e.changed));
                end
            end
            busy_q = busy;
            chg_q  = ubrr_changed;
        end
    end

    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check1("rst_UBRR", 32'(UBRR), 32'd0);
        check1("rst_valid", 32'(ubrr_valid), 32'd0);
        check1("rst_changed", 32'(ubrr_changed), 32'd0);
        check1("rst_busy", 32'(busy), 32'd0);
        check1("rst_err", 32'(err), 32'd0);
        mon_en = 1'b1;

        // 868 clocks/bit, then the same again (no change pulse).
        build_char(8'h55, 868); run_frame();
        build_char(8'h55, 868); run_frame();

        // 16 clocks/bit good, 3 clocks/bit below minimum.
        build_char(8'h55, 16); run_frame();
        build_char(8'h55, 3);  run_frame();

        // Restart while busy: partial measurement is discarded.
        pulse_start();
        rx = 1'b0;
        repeat (50) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        build_char(8'h55, 20); run_frame();

        // Unevenly spaced edges: 0x5D followed by a 0x55 after a gap.
        build_char(8'h5D, 100);
        add_seg(1'b1, 200);
        build_char(8'h55, 100);
        run_frame();

        // Randomized good frames.
        for (int i = 0; i < 8; i++) begin
            build_char(8'h55, $urandom_range(80, 4));
            run_frame();
        end

        // 10416 clocks/bit: span overflows the counter; truncated once it has.
        add_seg(1'b0, 10416);
        add_seg(1'b1, 10416);
        add_seg(1'b0, 10416);
        add_seg(1'b1, 1752);
        run_frame();

        // Start bit then line held low.
        add_seg(1'b0, 33000);
        run_frame();

        // Reset mid-measurement clears everything.
        pulse_start();
        e.err = 1'b0; e.valid = 1'b0; e.ubrr = 0; e.changed = 1'b0;
        exp_q.push_back(e);
        model_ubrr = 0;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check1("midrst_UBRR", 32'(UBRR), 32'd0);
        check1("midrst_valid", 32'(ubrr_valid), 32'd0);
        check1("midrst_busy", 32'(busy), 32'd0);
        check1("midrst_err", 32'(err), 32'd0);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // A good frame after reset starts from UBRR=0 again.
        build_char(8'h55, 25); run_frame();

        check1("pending_expectations", 32'(exp_q.size()), 32'd0);
        check1("changed_pulse_count", 32'(obs_changes), 32'(exp_changes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
